// File: rtl/receive_que_arbiter.sv
`default_nettype none
// ============================================================================
// receive_que_arbiter
//   Round-robin arbiter streaming one complete receive-queue frame at a time
//   to the forwarding engine, with a stall watchdog that aborts dead grants.
//   Revision: 1.0
// ============================================================================
module receive_que_arbiter #(
  parameter int NUMBER_OF_PORTS   = 2,
  parameter int DATA_WIDTH        = 8,
  parameter int TIMEOUT_CYCLES    = 2048,
  parameter int GRANT_INDEX_WIDTH = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUMBER_OF_PORTS-1:0]            request_valid,
  input  logic [NUMBER_OF_PORTS*DATA_WIDTH-1:0] request_data,
  input  logic [NUMBER_OF_PORTS-1:0]            request_data_valid,
  input  logic [NUMBER_OF_PORTS-1:0]            request_last,
  output logic [NUMBER_OF_PORTS-1:0]            request_ready,
  output logic [NUMBER_OF_PORTS-1:0]            grant,
  output logic [GRANT_INDEX_WIDTH-1:0]          grant_index,
  output logic [DATA_WIDTH-1:0]                 output_data,
  output logic                                  output_valid,
  output logic                                  output_last,
  input  logic                                  output_ready,
  output logic                                  timeout_pulse,
  output logic [15:0]                           frames_forwarded
);

  localparam int GIW = GRANT_INDEX_WIDTH;
  localparam int CW  = GIW + 1;
  localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [WDW-1:0] WD_LIMIT  = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  PORTS_C   = CW'(NUMBER_OF_PORTS);
  localparam logic [GIW-1:0] LAST_PORT = GIW'(NUMBER_OF_PORTS - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic [GIW-1:0]             ptr_q, ptr_d;
  logic [GIW-1:0]             gidx_q, gidx_d;
  logic [NUMBER_OF_PORTS-1:0] grant_q, grant_d;
  logic [WDW-1:0]             wd_q, wd_d;
  logic                       tpulse_q, tpulse_d;
  logic [15:0]                frames_q, frames_d;

  logic                       pick_found;
  logic [GIW-1:0]             pick_idx;
  logic [CW-1:0]              cand;
  logic                       in_stream;
  logic                       transfer;
  logic [GIW-1:0]             ptr_next;

  // First requester at or above the pointer, wrapping modulo the port count.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUMBER_OF_PORTS; i++) begin
      cand = {1'b0, ptr_q} + CW'(i);
      if (cand >= PORTS_C) cand = cand - PORTS_C;
      if (!pick_found && request_valid[cand[GIW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[GIW-1:0];
      end
    end
  end

  assign in_stream    = (state_q == ST_STREAM);
  assign output_data  = in_stream ? request_data[gidx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign output_valid = in_stream & request_data_valid[gidx_q];
  assign output_last  = output_valid & request_last[gidx_q];
  assign transfer     = output_valid & output_ready;
  assign ptr_next     = (gidx_q == LAST_PORT) ? '0 : gidx_q + 1'b1;

  always_comb begin
    request_ready = '0;
    if (in_stream) request_ready[gidx_q] = output_ready;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    wd_d     = wd_q;
    tpulse_d = 1'b0;
    frames_d = frames_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d           = ST_STREAM;
          gidx_d            = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          wd_d              = '0;
        end
      end
      ST_STREAM: begin
        if (transfer) begin
          wd_d = '0;
          if (output_last) begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            gidx_d   = '0;
            ptr_d    = ptr_next;
            frames_d = frames_q + 16'd1;
          end
        end else if (wd_q == WD_LIMIT) begin
          // Abandon the grant; the partial frame lacks output_last downstream.
          state_d  = ST_IDLE;
          grant_d  = '0;
          gidx_d   = '0;
          ptr_d    = ptr_next;
          tpulse_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        gidx_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      wd_q     <= '0;
      tpulse_q <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      wd_q     <= wd_d;
      tpulse_q <= tpulse_d;
      frames_q <= frames_d;
    end
  end

  assign grant            = grant_q;
  assign grant_index      = gidx_q;
  assign timeout_pulse    = tpulse_q;
  assign frames_forwarded = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_receive_que_arbiter.sv
`default_nettype none
// ============================================================================
// tb_receive_que_arbiter
//   Two arbiters (2 ports/2048-cycle watchdog, 3 ports/16-cycle watchdog)
//   checked each cycle against a frame-level model plus directed literals.
//   Revision: 1.0
// ============================================================================
module tb_receive_que_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rv  [2];
  logic [3:0]  rdv [2];
  logic [3:0]  rl  [2];
  logic [31:0] rd  [2];
  logic        ordy[2];

  logic [1:0]  rr_0, gnt_0;
  logic [0:0]  gi_0;
  logic [7:0]  od_0;
  logic        ov_0, ol_0, tp_0;
  logic [15:0] ff_0;
  logic [2:0]  rr_1, gnt_1;
  logic [1:0]  gi_1;
  logic [7:0]  od_1;
  logic        ov_1, ol_1, tp_1;
  logic [15:0] ff_1;

  int total = 0;
  int bad   = 0;

  // Per-port frame sources and the reference model state.
  int src_frames[2][4], src_pos[2][4], src_fr[2][4], src_len[2][4];
  bit dv_en[2][4];
  int m_busy[2], m_owner[2], m_ptr[2], m_wd[2], m_frames[2], m_pulse[2];

  always #5 clock = ~clock;

  receive_que_arbiter #(.NUMBER_OF_PORTS(2), .DATA_WIDTH(8), .TIMEOUT_CYCLES(2048)) u_dut0 (
    .clock(clock), .reset(reset),
    .request_valid(rv[0][1:0]), .request_data(rd[0][15:0]),
    .request_data_valid(rdv[0][1:0]), .request_last(rl[0][1:0]),
    .request_ready(rr_0), .grant(gnt_0), .grant_index(gi_0),
    .output_data(od_0), .output_valid(ov_0), .output_last(ol_0),
    .output_ready(ordy[0]), .timeout_pulse(tp_0), .frames_forwarded(ff_0));

  receive_que_arbiter #(.NUMBER_OF_PORTS(3), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) u_dut1 (
    .clock(clock), .reset(reset),
    .request_valid(rv[1][2:0]), .request_data(rd[1][23:0]),
    .request_data_valid(rdv[1][2:0]), .request_last(rl[1][2:0]),
    .request_ready(rr_1), .grant(gnt_1), .grant_index(gi_1),
    .output_data(od_1), .output_valid(ov_1), .output_last(ol_1),
    .output_ready(ordy[1]), .timeout_pulse(tp_1), .frames_forwarded(ff_1));

  function automatic int np_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int to_of(input int k);
    return (k == 0) ? 2048 : 16;
  endfunction

  function automatic logic [7:0] byte_of(input int p, input int fr, input int pos);
    return 8'(((pos + 1) * 17) + p * 128 + fr * 5);
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s[dut%0d] t=%0t: got %0h want %0h", name, k, $time, act, want);
    end
  endtask

  task automatic get_outs(input int k, output logic [3:0] g, output logic [3:0] gi,
                          output logic [7:0] od, output logic ov, output logic ol,
                          output logic tp, output logic [3:0] rr, output logic [15:0] ff);
    if (k == 0) begin
      g = {2'b00, gnt_0}; gi = {3'b000, gi_0}; od = od_0; ov = ov_0; ol = ol_0;
      tp = tp_0; rr = {2'b00, rr_0}; ff = ff_0;
    end else begin
      g = {1'b0, gnt_1}; gi = {2'b00, gi_1}; od = od_1; ov = ov_1; ol = ol_1;
      tp = tp_1; rr = {1'b0, rr_1}; ff = ff_1;
    end
  endtask

  task automatic drive_inputs();
    bit have;
    for (int k = 0; k < 2; k++) begin
      rv[k] = '0; rdv[k] = '0; rl[k] = '0; rd[k] = '0;
      for (int p = 0; p < np_of(k); p++) begin
        have = (src_frames[k][p] > 0);
        rv[k][p]  = have;
        rdv[k][p] = have && dv_en[k][p];
        rl[k][p]  = have && (src_pos[k][p] == src_len[k][p] - 1);
        rd[k][p*8 +: 8] = have ? byte_of(p, src_fr[k][p], src_pos[k][p]) : 8'h00;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 0;
      m_wd[k] = 0; m_frames[k] = 0; m_pulse[k] = 0;
    end
  endtask

  task automatic model_step();
    int n, p, o;
    bit xfer, last, found;
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      n = np_of(k);
      m_pulse[k] = 0;
      if (m_busy[k] == 0) begin
        found = 0;
        for (int i = 0; i < n; i++) begin
          p = (m_ptr[k] + i) % n;
          if (!found && rv[k][p]) begin
            found = 1; m_busy[k] = 1; m_owner[k] = p; m_wd[k] = 0;
          end
        end
      end else begin
        o    = m_owner[k];
        xfer = rdv[k][o] && ordy[k];
        last = xfer && rl[k][o];
        if (xfer) begin
          src_pos[k][o]++;
          if (src_pos[k][o] == src_len[k][o]) begin
            src_pos[k][o] = 0;
            src_frames[k][o]--;
            src_fr[k][o]++;
          end
        end
        if (last) begin
          m_busy[k] = 0; m_frames[k] = (m_frames[k] + 1) % 65536; m_ptr[k] = (o + 1) % n;
        end else if (xfer) begin
          m_wd[k] = 0;
        end else if (m_wd[k] == to_of(k) - 1) begin
          m_busy[k] = 0; m_pulse[k] = 1; m_ptr[k] = (o + 1) % n;
        end else begin
          m_wd[k]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0]  g, gi, rr;
    logic [7:0]  od;
    logic        ov, ol, tp;
    logic [15:0] ff;
    int o;
    for (int k = 0; k < 2; k++) begin
      get_outs(k, g, gi, od, ov, ol, tp, rr, ff);
      o = m_owner[k];
      if (m_busy[k] != 0) begin
        check("grant", k, g, 32'(1 << o));
        check("grant_index", k, gi, o);
        check("output_data", k, od, rd[k][o*8 +: 8]);
        check("output_valid", k, ov, rdv[k][o]);
        check("output_last", k, ol, rdv[k][o] & rl[k][o]);
        check("request_ready", k, rr, ordy[k] ? 32'(1 << o) : 32'd0);
      end else begin
        check("grant_idle", k, g, 0);
        check("output_data_idle", k, od, 0);
        check("output_valid_idle", k, ov, 0);
        check("output_last_idle", k, ol, 0);
        check("request_ready_idle", k, rr, 0);
      end
      check("timeout_pulse", k, tp, m_pulse[k]);
      check("frames_forwarded", k, ff, m_frames[k]);
    end
  endtask

  task automatic settle();
    @(negedge clock);
    compare_all();
  endtask

  task automatic clk_edge();
    @(posedge clock);
    model_step();
    #1;
    drive_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      clk_edge();
    end
  endtask

  task automatic wait_grant(input int k, output logic [3:0] g);
    logic [3:0] gi, rr;
    logic [7:0] od;
    logic ov, ol, tp;
    logic [15:0] ff;
    bit seen;
    seen = 0;
    g = '0;
    for (int n = 0; n < 40; n++) begin
      settle();
      get_outs(k, g, gi, od, ov, ol, tp, rr, ff);
      if (g != 0) begin
        seen = 1;
        break;
      end
      clk_edge();
    end
    check("grant_arrives", k, seen, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    drive_inputs();
    settle();
    clk_edge();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int         seq[$];
    int         want_seq[4];
    logic [3:0] g, prev;
    logic [7:0] eb;

    for (int k = 0; k < 2; k++) begin
      ordy[k] = 1'b1;
      for (int p = 0; p < 4; p++) begin
        src_frames[k][p] = 0; src_pos[k][p] = 0; src_fr[k][p] = 0;
        src_len[k][p] = 1; dv_en[k][p] = 1'b1;
      end
    end
    model_reset();
    drive_inputs();

    // Reset state.
    settle();
    check("rst_grant", 0, gnt_0, 0);
    check("rst_grant_index", 0, gi_0, 0);
    check("rst_frames", 1, ff_1, 0);
    check("rst_timeout", 1, tp_1, 0);
    clk_edge();
    reset = 1'b0;

    // Single 4-byte frame on port 0.
    src_len[0][0] = 4; src_frames[0][0] = 1;
    drive_inputs();
    settle();
    check("t1_grant_before", 0, gnt_0, 0);
    clk_edge();
    for (int i = 0; i < 4; i++) begin
      settle();
      eb = 8'((i + 1) * 17);
      check("t1_grant", 0, gnt_0, 2'b01);
      check("t1_data", 0, od_0, eb);
      check("t1_last", 0, ol_0, (i == 3));
      clk_edge();
    end
    settle();
    check("t1_frames", 0, ff_0, 1);
    check("t1_grant_after", 0, gnt_0, 0);
    clk_edge();

    // Pointer moved to 1: with both requesting, port 1 wins.
    src_frames[0][0] = 1; src_len[0][1] = 2; src_frames[0][1] = 1;
    drive_inputs();
    settle();
    clk_edge();
    settle();
    check("ptr_after_t1", 0, gnt_0, 2'b10);
    clk_edge();
    run(10);
    check("ptr_frames", 0, ff_0, 3);

    // Reset while port 0 is mid-frame.
    src_len[0][0] = 6; src_frames[0][0] = 1;
    drive_inputs();
    wait_grant(0, g);
    check("rst_mid_grant_pre", 0, g, 2'b01);
    clk_edge();
    settle();
    clk_edge();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_mid_grant", 0, gnt_0, 0);
    check("rst_mid_valid", 0, ov_0, 0);
    check("rst_mid_ready", 0, rr_0, 0);
    settle();
    clk_edge();
    reset = 1'b0;
    src_frames[0][0] = 0; src_pos[0][0] = 0;
    src_len[0][1] = 2; src_frames[0][1] = 1;
    drive_inputs();
    settle();
    clk_edge();
    settle();
    check("rst_then_port1", 0, gnt_0, 2'b10);
    clk_edge();
    run(4);
    check("rst_then_frames", 0, ff_0, 1);

    // Both ports continuously requesting 2-byte frames.
    src_len[0][0] = 2; src_frames[0][0] = 2;
    src_len[0][1] = 2; src_frames[0][1] = 2;
    drive_inputs();
    want_seq = '{0, 1, 0, 1};
    prev = '0;
    for (int c = 0; c < 20; c++) begin
      settle();
      if (gnt_0 != 0 && prev == 0) seq.push_back(gnt_0 == 2'b01 ? 0 : (gnt_0 == 2'b10 ? 1 : 9));
      prev = {2'b00, gnt_0};
      clk_edge();
    end
    check("alt_count", 0, seq.size(), 4);
    for (int i = 0; i < 4; i++) check("alt_order", 0, (i < seq.size()) ? seq[i] : -1, want_seq[i]);
    check("alt_frames", 0, ff_0, 5);

    // Backpressure on port 1, well inside the watchdog window.
    src_len[0][1] = 4; src_frames[0][1] = 1;
    drive_inputs();
    wait_grant(0, g);
    check("bp_grant", 0, g, 2'b10);
    clk_edge();
    ordy[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      settle();
      check("bp_ready_low", 0, rr_0, 2'b00);
      check("bp_valid_held", 0, ov_0, 1);
      check("bp_no_abort", 0, tp_0, 0);
      clk_edge();
    end
    ordy[0] = 1'b1;
    settle();
    check("bp_ready_back", 0, rr_0, 2'b10);
    check("bp_next_byte", 0, od_0, 8'hB6);
    clk_edge();
    run(6);
    check("bp_frames", 0, ff_0, 6);

    // Stall on the 3-port, 16-cycle watchdog instance.
    src_len[1][0] = 3; src_frames[1][0] = 1; dv_en[1][0] = 1'b0;
    drive_inputs();
    wait_grant(1, g);
    check("stall_grant", 1, g, 3'b001);
    clk_edge();
    for (int j = 1; j <= 16; j++) begin
      settle();
      check("stall_pulse", 1, tp_1, (j == 16));
      if (j == 16) begin
        check("stall_idle", 1, gnt_1, 0);
        check("stall_frames", 1, ff_1, 0);
        dv_en[1][0] = 1'b1;
        src_len[1][1] = 2; src_frames[1][1] = 1;
        drive_inputs();
      end
      clk_edge();
    end
    settle();
    check("stall_ptr_advanced", 1, gnt_1, 3'b010);
    clk_edge();
    run(12);
    check("stall_after_frames", 1, ff_1, 2);

    // Three-way rotation from a fresh pointer.
    do_reset();
    src_len[1][0] = 2; src_frames[1][0] = 2;
    src_len[1][1] = 2; src_frames[1][1] = 1;
    src_len[1][2] = 2; src_frames[1][2] = 1;
    drive_inputs();
    want_seq = '{0, 1, 2, 0};
    seq.delete();
    prev = '0;
    for (int c = 0; c < 20; c++) begin
      settle();
      check("rot_index_range", 1, (gi_1 <= 2'd2), 1);
      if (gnt_1 != 0 && prev == 0)
        seq.push_back(gnt_1 == 3'b001 ? 0 : (gnt_1 == 3'b010 ? 1 : (gnt_1 == 3'b100 ? 2 : 9)));
      prev = {1'b0, gnt_1};
      clk_edge();
    end
    check("rot_count", 1, seq.size(), 4);
    for (int i = 0; i < 4; i++) check("rot_order", 1, (i < seq.size()) ? seq[i] : -1, want_seq[i]);
    check("rot_frames", 1, ff_1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
